// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ahb_pkg
//  Description : AHB-Lite encodings and the boot-loader state type used by
//                the ahb_boot_loader block.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_FILL = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Packs a little-endian byte stream into 32-bit words. A
//                2-bit counter tracks the byte lane and wraps 3->0;
//                word_valid pulses on the cycle the fourth byte is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic [31:0] word_held,
    output logic        word_valid
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] shift_q;
    logic [31:0] shift_d;

    // Shift new bytes in from the top so the first byte lands in bits [7:0].
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_next  = {byte_in, shift_q[31:8]};
        word_valid = 1'b0;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (byte_en) begin
            cnt_d      = cnt_q + 2'd1;
            shift_d    = word_next;
            word_valid = (cnt_q == 2'd3);
        end
    end

    // Byte-lane counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_held = shift_q;

endmodule
`default_nettype wire

// File: rtl/ahb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_boot_loader
//  Description : AHB-Lite master that receives a program image over a byte
//                stream (32-bit LE word count, then LE data words) and writes
//                it to consecutive RAM words with single NONSEQ transfers.
//                Holds the CPU in reset until the image is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    import ahb_pkg::*;

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

    loader_state_t    state_q;
    loader_state_t    state_d;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] index_d;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;
    logic [IDX_W-1:0] index_inc;
    logic [31:0]      hwdata_q;
    logic [31:0]      hwdata_d;
    logic             started_q;

    logic             byte_en;
    logic             pk_clear;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic [31:0]      pk_held;

    // Header and data bytes share one packer; only the active state decides
    // what the completed word means.
    byte_packer u_packer (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .clear      (pk_clear),
        .byte_en    (byte_en),
        .byte_in    (rx_data),
        .word_next  (pk_word),
        .word_held  (pk_held),
        .word_valid (pk_valid)
    );

    assign byte_en   = rx_valid && rx_ready;
    assign pk_clear  = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign index_inc = index_q + IDX_W'(1);

    // Constant transfer attributes: single word transfers only.
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA;
    assign HWDATA = hwdata_q;
    assign HADDR  = BASE_ADDR + 32'({index_q, 2'b00});

    // Next-state and output decode; address and data phases never overlap.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        count_d  = count_q;
        hwdata_d = hwdata_q;
        rx_ready = 1'b0;
        HTRANS   = HTRANS_IDLE;
        HWRITE   = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            ST_HDR: begin
                // Stay deaf for the very first cycle out of reset.
                rx_ready = started_q;
                if (pk_valid) begin
                    if (pk_word == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (pk_word > 32'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_FILL;
                        index_d = '0;
                        count_d = pk_word[IDX_W-1:0];
                    end
                end
            end
            ST_FILL: begin
                rx_ready = 1'b1;
                if (pk_valid) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                if (HREADY) begin
                    state_d  = ST_DATA;
                    hwdata_d = pk_held;
                end
            end
            ST_DATA: begin
                // IDLE is already on the bus, so an error response can be
                // taken on its first cycle.
                if (HRESP) begin
                    state_d = ST_ERR;
                end else if (HREADY) begin
                    index_d = index_inc;
                    state_d = (index_inc == count_q) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ST_ERR: begin
                error = 1'b1;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // State, word index/count and write-data registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_HDR;
            index_q   <= '0;
            count_q   <= '0;
            hwdata_q  <= 32'd0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            hwdata_q  <= hwdata_d;
            started_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_boot_loader
//  Description : Self-checking bench for ahb_boot_loader with an AHB RAM
//                slave model, a write scoreboard and hand-built corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        HCLK     = 1'b0;
    logic        HRESETn  = 1'b0;
    logic [7:0]  rx_data  = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY   = 1'b1;
    logic        HRESP    = 1'b0;
    logic        cpu_hold;
    logic        done;
    logic        error;

    ahb_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(4096)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- cycle counter and AHB RAM slave / monitor -------------
    int          cyc = 0;
    logic        dph_valid = 1'b0;
    logic [31:0] dph_addr = 32'd0;
    logic        prev_stall_a = 1'b0;
    logic        prev_stall_d = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;
    int          proto_err = 0;
    int          nonseq_cnt = 0;
    int          obs_wr = 0;
    int          last_wr_cyc = 0;
    logic [31:0] obs_addr [0:255];
    logic [31:0] obs_data [0:255];
    logic [31:0] mem [0:63];

    always @(posedge HCLK) cyc <= cyc + 1;

    // Samples the bus mid-cycle; the upcoming rising edge acts on these values.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dph_valid    <= 1'b0;
            prev_stall_a <= 1'b0;
            prev_stall_d <= 1'b0;
        end else begin
            if (HTRANS != 2'b00 && HTRANS != 2'b10) proto_err <= proto_err + 1;
            if (dph_valid && HTRANS == 2'b10) proto_err <= proto_err + 1;
            if (prev_stall_a && (HADDR != prev_addr || HTRANS != 2'b10 || HWRITE !== 1'b1))
                proto_err <= proto_err + 1;
            if (prev_stall_d && HWDATA != prev_wdata) proto_err <= proto_err + 1;
            prev_stall_a <= (HTRANS == 2'b10) && !HREADY;
            prev_addr    <= HADDR;
            prev_stall_d <= dph_valid && !HREADY;
            prev_wdata   <= HWDATA;
            if (dph_valid && HREADY && !HRESP) begin
                mem[6'((dph_addr - BASE) >> 2)] <= HWDATA;
                obs_addr[obs_wr] <= dph_addr;
                obs_data[obs_wr] <= HWDATA;
                obs_wr           <= obs_wr + 1;
                last_wr_cyc      <= cyc;
            end
            if (HTRANS == 2'b10 && HREADY) begin
                dph_valid  <= 1'b1;
                dph_addr   <= HADDR;
                nonseq_cnt <= nonseq_cnt + 1;
            end else if (dph_valid && HREADY) begin
                dph_valid <= 1'b0;
            end
        end
    end

    // ---------------- checking infrastructure -------------------------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          obs_rd  = 0;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        acc = 1'b0;
        if (gap) begin
            rx_valid = 1'b0;
            @(posedge HCLK); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge HCLK);
            acc = rx_ready;
            @(posedge HCLK); #1;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_accept: byte %h not taken, got timeout expected accept", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic drain(input string tag);
        logic [63:0] e;
        chk({tag, "_wr_count"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
        while (obs_rd < obs_wr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_haddr"},  obs_addr[obs_rd], e[63:32]);
            chk({tag, "_hwdata"}, obs_data[obs_rd], e[31:0]);
            obs_rd++;
        end
        obs_rd = obs_wr;
        exp_q.delete();
    endtask

    task automatic do_reset();
        HRESETn  = 1'b0;
        rx_valid = 1'b0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        obs_rd  = obs_wr;
        exp_q.delete();
        chk("rst_htrans",   32'(HTRANS),   32'h0);
        chk("rst_hwrite",   32'(HWRITE),   32'h0);
        chk("rst_haddr",    HADDR,         BASE);
        chk("rst_hwdata",   HWDATA,        32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'h1);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_error",    32'(error),    32'h0);
        chk("rst_hsize",    32'(HSIZE),    32'h2);
        chk("rst_hburst",   32'(HBURST),   32'h0);
        chk("rst_hprot",    32'(HPROT),    32'h3);
    endtask

    task automatic wait_end(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge HCLK);
            if (done || error) begin
                at_cyc = cyc;
                break;
            end
        end
        @(posedge HCLK); #1;
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct packed {
        logic [31:0]      hdr;
        logic [7:0]       nsend;
        logic [2:0][31:0] w;
        logic             gap;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_wr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [0:NV-1];

    function automatic vec_t mk(input logic [31:0] hdr, input int nsend,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input bit gap,
                                input bit d, input bit e, input int wr);
        vec_t m;
        m.hdr      = hdr;
        m.nsend    = 8'(nsend);
        m.w[0]     = w0;
        m.w[1]     = w1;
        m.w[2]     = w2;
        m.gap      = gap;
        m.exp_done = d;
        m.exp_err  = e;
        m.exp_wr   = 8'(wr);
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int p0;
        int dcyc;

        vecs[0] = mk(32'd2,          2, 32'h44332211, 32'hDDCCBBAA, 32'h0, 1'b0, 1'b1, 1'b0, 2);
        vecs[1] = mk(32'd0,          0, 32'h0,        32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 0);
        vecs[2] = mk(32'h0000_1001,  0, 32'h0,        32'h0,        32'h0, 1'b0, 1'b0, 1'b1, 0);
        vecs[3] = mk(32'd1,          1, 32'hDEADBEEF, 32'h0,        32'h0, 1'b1, 1'b1, 1'b0, 1);
        vecs[4] = mk(32'd3,          3, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 1'b0, 1'b1, 1'b0, 3);
        vecs[5] = mk(32'hFFFF_FFFF,  0, 32'h0,        32'h0,        32'h0, 1'b0, 1'b0, 1'b1, 0);
        vecs[6] = mk(32'h0000_1000,  0, 32'h0,        32'h0,        32'h0, 1'b0, 1'b0, 1'b0, 0);
        vecs[7] = mk(32'd3,          2, 32'h5A5A0001, 32'hA5A50002, 32'h0, 1'b1, 1'b0, 1'b0, 2);

        // ---- table-driven images ----
        for (int v = 0; v < NV; v++) begin
            do_reset();
            n0 = nonseq_cnt;
            send_word(vecs[v].hdr, vecs[v].gap);
            for (int i = 0; i < int'(vecs[v].nsend); i++) begin
                if (i < int'(vecs[v].exp_wr))
                    exp_q.push_back({BASE + 32'(i * 4), vecs[v].w[i]});
                send_word(vecs[v].w[i], vecs[v].gap);
            end
            if (vecs[v].exp_done || vecs[v].exp_err) begin
                wait_end(200, dcyc);
            end else begin
                repeat (20) @(posedge HCLK);
                #1;
                dcyc = -1;
            end
            chk($sformatf("v%0d_done", v),     32'(done),     32'(vecs[v].exp_done));
            chk($sformatf("v%0d_error", v),    32'(error),    32'(vecs[v].exp_err));
            chk($sformatf("v%0d_cpu_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
            chk($sformatf("v%0d_rx_ready", v), 32'(rx_ready),
                32'(!(vecs[v].exp_done || vecs[v].exp_err)));
            chk($sformatf("v%0d_nonseq", v),   32'(nonseq_cnt - n0), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_done && vecs[v].exp_wr != 8'd0)
                chk($sformatf("v%0d_done_cycle", v), 32'(dcyc), 32'(last_wr_cyc + 1));
            drain($sformatf("v%0d", v));
            if (v == 0) begin
                chk("v0_ram0", mem[0], 32'h44332211);
                chk("v0_ram1", mem[1], 32'hDDCCBBAA);
            end
        end

        // ---- zero-length image: done right after the 4th header byte ----
        do_reset();
        n0 = nonseq_cnt;
        send_word(32'd0, 1'b0);
        chk("hdr0_done_next", 32'(done),     32'h1);
        chk("hdr0_rx_ready",  32'(rx_ready), 32'h0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        rx_valid = 1'b0;
        chk("hdr0_done_held", 32'(done), 32'h1);
        chk("hdr0_nonseq",    32'(nonseq_cnt - n0), 32'h0);
        drain("hdr0");

        // ---- wait states in address and data phases ----
        do_reset();
        n0 = nonseq_cnt;
        p0 = proto_err;
        send_word(32'd1, 1'b0);
        exp_q.push_back({BASE, 32'hCAFEF00D});
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFE, 1'b0);
        HREADY = 1'b0;
        send_byte(8'hCA, 1'b0);
        chk("ws_a_htrans", 32'(HTRANS), 32'h2);
        chk("ws_a_haddr",  HADDR,       BASE);
        chk("ws_a_hwrite", 32'(HWRITE), 32'h1);
        repeat (2) @(posedge HCLK);
        #1;
        chk("ws_a_hold", 32'(HTRANS), 32'h2);
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        chk("ws_d_htrans", 32'(HTRANS), 32'h0);
        chk("ws_d_hwdata", HWDATA,      32'hCAFEF00D);
        repeat (2) @(posedge HCLK);
        #1;
        chk("ws_d_hold", HWDATA, 32'hCAFEF00D);
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        chk("ws_done",   32'(done),             32'h1);
        chk("ws_stable", 32'(proto_err - p0),   32'h0);
        chk("ws_nonseq", 32'(nonseq_cnt - n0),  32'h1);
        drain("ws");

        // ---- two-cycle error response on the first write ----
        do_reset();
        send_word(32'd1, 1'b0);
        send_word(32'h12345678, 1'b0);
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        HRESP  = 1'b1;
        chk("err_c1_htrans", 32'(HTRANS), 32'h0);
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        chk("err_c2_htrans", 32'(HTRANS), 32'h0);
        chk("err_c2_error",  32'(error),  32'h1);
        @(posedge HCLK); #1;
        HRESP = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("err_sticky",   32'(error),    32'h1);
        chk("err_cpu_hold", 32'(cpu_hold), 32'h1);
        chk("err_rx_ready", 32'(rx_ready), 32'h0);
        chk("err_done",     32'(done),     32'h0);
        drain("err");

        // ---- reset during the data phase of the third word ----
        do_reset();
        send_word(32'd4, 1'b0);
        exp_q.push_back({BASE,         32'h11110000});
        send_word(32'h11110000, 1'b0);
        exp_q.push_back({BASE + 32'd4, 32'h22220001});
        send_word(32'h22220001, 1'b0);
        send_word(32'h33330002, 1'b0);
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        chk("rstmid_in_data", 32'(HTRANS), 32'h0);
        @(negedge HCLK);
        drain("rstmid_pre");
        @(posedge HCLK); #1;
        do_reset();
        send_word(32'd1, 1'b0);
        exp_q.push_back({BASE, 32'h0BADF00D});
        send_word(32'h0BADF00D, 1'b0);
        wait_end(200, dcyc);
        chk("rstmid_done", 32'(done),  32'h1);
        chk("rstmid_ram0", mem[0],     32'h0BADF00D);
        drain("rstmid_post");

        chk("protocol", 32'(proto_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
